// File: rtl/board_check.sv
// Shot-resolution and ship-map stage for the battleship game: per-side ship/shot maps, shot classification, ship counts, win flag.
// Optional feature: define BOARD_CHECK_REPEAT_EN to report repeat shots; otherwise a repeat is a plain miss.
module board_check #(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int MAX_SHIPS = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           new_game,
  input  logic                           place_en,
  input  logic                           place_side,
  input  logic [$clog2(ROWS)-1:0]        place_row,
  input  logic [$clog2(COLS)-1:0]        place_col,
  input  logic                           shot_req,
  input  logic                           shot_side,
  input  logic [$clog2(ROWS)-1:0]        shot_row,
  input  logic [$clog2(COLS)-1:0]        shot_col,
  output logic                           busy,
  output logic                           done,
  output logic                           hit,
  output logic                           repeat_shot,
  output logic                           invalid,
  output logic                           win,
  output logic [$clog2(MAX_SHIPS+1)-1:0] ships_p,
  output logic [$clog2(MAX_SHIPS+1)-1:0] ships_pc
);
  // state  | meaning
  // IDLE   | accept placements and shot requests
  // LOOKUP | register target cell bits and range check
  // UPDATE | classify shot, update maps, counts and flags
  // RESP   | done pulse, result valid
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(MAX_SHIPS + 1);
  localparam int N  = ROWS * COLS;
  localparam logic [RW:0]   ROWS_L = (RW + 1)'(ROWS);
  localparam logic [CW:0]   COLS_L = (CW + 1)'(COLS);
  localparam logic [N-1:0]  ONE    = {{(N - 1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] MAX_L  = SW'(MAX_SHIPS);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_RESP} state_t;
  state_t r_state, w_next;

  logic [N-1:0]  r_occ  [2];
  logic [N-1:0]  r_shot [2];
  logic [SW-1:0] r_cnt  [2];
  logic          r_side;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_tgt_occ, r_tgt_shot, r_tgt_inv;
  logic          r_hit, r_rep, r_inv, r_win;

  logic          w_clr;
  logic [6:0]    w_pl_idx, w_sh_idx;
  logic [N-1:0]  w_pl_mask, w_sh_mask;
  logic          w_pl_ok, w_sh_inv, w_tgt;
  logic          w_hit, w_rep, w_mark;
  logic [SW-1:0] w_cnt_after;

  assign w_clr = rst | new_game;

  always_ff @(posedge clk) begin
    if (w_clr) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (shot_req) w_next = S_LOOKUP;
      S_LOOKUP: w_next = S_UPDATE;
      S_UPDATE: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_pl_idx  = 7'(place_row) * 7'(COLS) + 7'(place_col);
  assign w_pl_mask = ONE << w_pl_idx;
  assign w_pl_ok   = (r_state == S_IDLE) && !shot_req && place_en
                     && ({1'b0, place_row} < ROWS_L) && ({1'b0, place_col} < COLS_L)
                     && !(|(r_occ[place_side] & w_pl_mask))
                     && (r_cnt[place_side] != MAX_L);

  // Out-of-range coordinates may alias an in-range index; the range flag overrides them.
  assign w_sh_idx  = 7'(r_row) * 7'(COLS) + 7'(r_col);
  assign w_sh_mask = ONE << w_sh_idx;
  assign w_sh_inv  = !(({1'b0, r_row} < ROWS_L) && ({1'b0, r_col} < COLS_L));
  assign w_tgt     = ~r_side;

  assign w_hit = !r_tgt_inv && !r_tgt_shot && r_tgt_occ;
`ifdef BOARD_CHECK_REPEAT_EN
  assign w_rep = !r_tgt_inv && r_tgt_shot;
`else
  assign w_rep = 1'b0;
`endif
  assign w_mark      = !r_tgt_inv && !w_rep;
  assign w_cnt_after = w_hit ? r_cnt[w_tgt] - SW'(1) : r_cnt[w_tgt];

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_occ[0]   <= '0;
      r_occ[1]   <= '0;
      r_shot[0]  <= '0;
      r_shot[1]  <= '0;
      r_cnt[0]   <= '0;
      r_cnt[1]   <= '0;
      r_side     <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_tgt_occ  <= 1'b0;
      r_tgt_shot <= 1'b0;
      r_tgt_inv  <= 1'b0;
      r_hit      <= 1'b0;
      r_rep      <= 1'b0;
      r_inv      <= 1'b0;
      r_win      <= 1'b0;
    end else begin
      if (w_pl_ok) begin
        r_occ[place_side] <= r_occ[place_side] | w_pl_mask;
        r_cnt[place_side] <= r_cnt[place_side] + SW'(1);
      end
      case (r_state)
        S_IDLE: if (shot_req) begin
          r_side <= shot_side;
          r_row  <= shot_row;
          r_col  <= shot_col;
        end
        S_LOOKUP: begin
          r_tgt_inv  <= w_sh_inv;
          r_tgt_occ  <= |(r_occ[w_tgt] & w_sh_mask);
          r_tgt_shot <= |(r_shot[w_tgt] & w_sh_mask);
        end
        S_UPDATE: begin
          r_inv <= r_tgt_inv;
          r_rep <= w_rep;
          r_hit <= w_hit;
          r_win <= (w_cnt_after == '0);
          if (w_mark) r_shot[w_tgt] <= r_shot[w_tgt] | w_sh_mask;
          r_cnt[w_tgt] <= w_cnt_after;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_RESP);
  assign hit         = r_hit;
  assign repeat_shot = r_rep;
  assign invalid     = r_inv;
  assign win         = r_win;
  assign ships_p     = r_cnt[0];
  assign ships_pc    = r_cnt[1];
endmodule

// File: tb/tb_board_check.sv
// Bench for board_check: directed scenarios plus randomized placements/shots against a cell-array model.
module tb_board_check;
  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int MAXS = 5;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(MAXS + 1);
`ifdef BOARD_CHECK_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, new_game = 1'b0;
  logic place_en = 1'b0, place_side = 1'b0;
  logic [RW-1:0] place_row = '0, shot_row = '0;
  logic [CW-1:0] place_col = '0, shot_col = '0;
  logic shot_req = 1'b0, shot_side = 1'b0;
  logic busy, done, hit, repeat_shot, invalid, win;
  logic [SW-1:0] ships_p, ships_pc;

  int tests = 0;
  int fails = 0;

  bit m_occ  [2][ROWS][COLS];
  bit m_shot [2][ROWS][COLS];
  int m_cnt  [2];

  board_check #(.ROWS(ROWS), .COLS(COLS), .MAX_SHIPS(MAXS)) dut (
    .clk(clk), .rst(rst), .new_game(new_game),
    .place_en(place_en), .place_side(place_side), .place_row(place_row), .place_col(place_col),
    .shot_req(shot_req), .shot_side(shot_side), .shot_row(shot_row), .shot_col(shot_col),
    .busy(busy), .done(done), .hit(hit), .repeat_shot(repeat_shot), .invalid(invalid),
    .win(win), .ships_p(ships_p), .ships_pc(ships_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          m_occ[s][r][c]  = 1'b0;
          m_shot[s][r][c] = 1'b0;
        end
    end
  endtask

  task automatic model_place(input int s, input int r, input int c);
    if (r < ROWS && c < COLS && m_cnt[s] < MAXS && !m_occ[s][r][c]) begin
      m_occ[s][r][c] = 1'b1;
      m_cnt[s]++;
    end
  endtask

  // Expected flags {hit, repeat, invalid, win}; shot_side 0 targets the PC board (index 1).
  task automatic model_shot(input int s, input int r, input int c, output logic [3:0] e);
    int t;
    logic eh, er, ei;
    t = (s == 0) ? 1 : 0;
    eh = 1'b0; er = 1'b0; ei = 1'b0;
    if (r >= ROWS || c >= COLS) ei = 1'b1;
    else if (m_shot[t][r][c]) er = REP_EN;
    else begin
      m_shot[t][r][c] = 1'b1;
      if (m_occ[t][r][c]) begin
        eh = 1'b1;
        m_cnt[t]--;
      end
    end
    e = {eh, er, ei, (m_cnt[t] == 0)};
  endtask

  task automatic do_place(input int s, input int r, input int c);
    place_side = s[0]; place_row = RW'(r); place_col = CW'(c); place_en = 1'b1;
    tick();
    place_en = 1'b0;
  endtask

  // Returns the cycle on which done was seen (1 = cycle after accept) and the outputs at that point.
  task automatic do_shot(input int s, input int r, input int c, output int lat,
                         output logic [3:0] f, output int sp, output int spc);
    shot_side = s[0]; shot_row = RW'(r); shot_col = CW'(c); shot_req = 1'b1;
    tick();
    shot_req = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    f = {hit, repeat_shot, invalid, win};
    sp = int'(ships_p);
    spc = int'(ships_pc);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tests++;
    if ({busy, done, hit, repeat_shot, invalid, win} !== 6'b0 || ships_p !== '0 || ships_pc !== '0) begin
      fails++;
      $display("FAIL reset got busy/done/flags=%b ships=%0d/%0d exp all 0",
               {busy, done, hit, repeat_shot, invalid, win}, ships_p, ships_pc);
    end
  endtask

  task automatic test_place();
    do_place(0, 1, 2);
    do_place(1, 0, 0);
    do_place(1, 4, 4);
    tests++;
    if (ships_p !== SW'(1) || ships_pc !== SW'(2)) begin
      fails++;
      $display("FAIL place_counts got %0d/%0d exp 1/2", ships_p, ships_pc);
    end
    do_place(1, 0, 0);
    do_place(1, 5, 0);
    do_place(0, 2, 7);
    tests++;
    if (ships_p !== SW'(1) || ships_pc !== SW'(2)) begin
      fails++;
      $display("FAIL place_rejects got %0d/%0d exp 1/2", ships_p, ships_pc);
    end
  endtask

  task automatic test_shots();
    int sh [5][3] = '{'{0,0,0}, '{0,4,4}, '{1,3,3}, '{1,3,3}, '{0,5,0}};
    logic [3:0] ef [5] = '{4'b1000, 4'b1001, 4'b0000, {1'b0, REP_EN, 2'b00}, 4'b0011};
    int ep [5] = '{1, 1, 1, 1, 1};
    int epc [5] = '{1, 0, 0, 0, 0};
    int lat, sp, spc;
    logic [3:0] f;
    for (int i = 0; i < 5; i++) begin
      do_shot(sh[i][0], sh[i][1], sh[i][2], lat, f, sp, spc);
      tests++;
      if (lat !== 3) begin
        fails++;
        $display("FAIL shot%0d_latency got %0d exp 3", i, lat);
      end
      tests++;
      if (f !== ef[i]) begin
        fails++;
        $display("FAIL shot%0d_flags got %b exp %b (hit,rep,inv,win)", i, f, ef[i]);
      end
      tests++;
      if (sp !== ep[i] || spc !== epc[i]) begin
        fails++;
        $display("FAIL shot%0d_counts got %0d/%0d exp %0d/%0d", i, sp, spc, ep[i], epc[i]);
      end
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL shot%0d_pulse_end got done=%b busy=%b exp 0/0", i, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    shot_side = 1'b0; shot_row = RW'(0); shot_col = CW'(1); shot_req = 1'b1;
    place_side = 1'b0; place_row = RW'(2); place_col = CW'(2); place_en = 1'b1;
    tick();
    shot_req = 1'b0; place_en = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_busy got %b exp 1", busy);
    end
    shot_side = 1'b1; shot_row = RW'(1); shot_col = CW'(2); shot_req = 1'b1;
    place_side = 1'b1; place_row = RW'(1); place_col = CW'(1); place_en = 1'b1;
    tick();
    shot_req = 1'b0; place_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    tests++;
    if (dones !== 1) begin
      fails++;
      $display("FAIL b2b_done_count got %0d exp 1", dones);
    end
    tests++;
    if (ships_p !== SW'(1) || ships_pc !== SW'(0) || hit !== 1'b0 || win !== 1'b1) begin
      fails++;
      $display("FAIL b2b_state got ships=%0d/%0d hit=%b win=%b exp 1/0 0 1", ships_p, ships_pc, hit, win);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    shot_side = 1'b1; shot_row = RW'(1); shot_col = CW'(2); shot_req = 1'b1;
    tick();
    shot_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({busy, done, hit, repeat_shot, invalid, win} !== 6'b0 || ships_p !== '0 || ships_pc !== '0) begin
      fails++;
      $display("FAIL reset_mid got busy/done/flags=%b ships=%0d/%0d exp all 0",
               {busy, done, hit, repeat_shot, invalid, win}, ships_p, ships_pc);
    end
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    tests++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL reset_mid_done got %0d exp 0", dones);
    end
  endtask

  task automatic test_random();
    int s, r, c, lat, sp, spc;
    logic [3:0] f, e;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_clear();
    tests++;
    if (ships_p !== '0 || ships_pc !== '0) begin
      fails++;
      $display("FAIL new_game got %0d/%0d exp 0/0", ships_p, ships_pc);
    end
    for (int it = 0; it < 300; it++) begin
      s = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 5));
      c = int'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) begin
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model_clear();
      end else if ($urandom_range(0, 9) < 4) begin
        do_place(s, r, c);
        model_place(s, r, c);
        tests++;
        if (int'(ships_p) !== m_cnt[0] || int'(ships_pc) !== m_cnt[1]) begin
          fails++;
          $display("FAIL rnd_place%0d got %0d/%0d exp %0d/%0d", it, ships_p, ships_pc, m_cnt[0], m_cnt[1]);
        end
      end else begin
        do_shot(s, r, c, lat, f, sp, spc);
        model_shot(s, r, c, e);
        tests++;
        if (lat !== 3 || f !== e || sp !== m_cnt[0] || spc !== m_cnt[1]) begin
          fails++;
          $display("FAIL rnd_shot%0d got lat=%0d flags=%b ships=%0d/%0d exp lat=3 flags=%b ships=%0d/%0d",
                   it, lat, f, sp, spc, e, m_cnt[0], m_cnt[1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_place();
    test_shots();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/board_check.md
# board_check

Shot-resolution and ship-map stage for the battleship game. It sits directly beside the game FSM. The FSM loads ship positions during setup, issues one shot per turn, and waits in its "check cell" state for `done`. The block keeps ship and shot maps for both sides, classifies each shot (hit / miss / repeat / invalid), counts remaining ships per side and flags victory, which the FSM uses for its victory-check state.

## Interface
Parameters:
- ROWS, 5, board rows (2..8)
- COLS, 5, board columns (2..8)
- MAX_SHIPS, 5, max single-cell ships per side (1..ROWS*COLS)

Ports (RW = $clog2(ROWS), CW = $clog2(COLS), SW = $clog2(MAX_SHIPS+1)):
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- new_game  in  1  synchronous clear of maps and counts; same effect as rst
- place_en  in  1  place one ship (IDLE only)
- place_side  in  1  0 = player board, 1 = PC board
- place_row  in  RW  ship row
- place_col  in  CW  ship column
- shot_req  in  1  fire request (IDLE only)
- shot_side  in  1  0 = player fires at PC board, 1 = PC fires at player board
- shot_row  in  RW  target row
- shot_col  in  CW  target column
- busy  out  1  high in LOOKUP, UPDATE, RESP
- done  out  1  one-cycle pulse, result valid (FSM input V)
- hit  out  1  last shot hit a ship
- repeat_shot  out  1  last shot targeted an already-shot cell
- invalid  out  1  last shot coordinates out of range
- win  out  1  target side of last shot has zero ships left
- ships_p  out  SW  ships placed and not yet sunk, player board
- ships_pc  out  SW  ships placed and not yet sunk, PC board

## Operation
- Storage: per side, an occupancy map and a shot map, each ROWS*COLS bits. Index = row*COLS + col.
- States: IDLE, LOOKUP, UPDATE, RESP.
- IDLE:
  - shot_req=1 → latch side/row/col, go to LOOKUP.
  - Otherwise, place_en=1 → set the occupancy bit and increment the side's count. Placement is ignored (no change) if out of range, the cell is already occupied, or the count equals MAX_SHIPS.
- LOOKUP: register the target cell's occupancy and shot bits. Register the range check (row ≥ ROWS or col ≥ COLS).
- UPDATE: classify in priority order invalid > repeat > hit > miss.
  - Hit or miss: set the shot bit.
  - Hit: decrement the target side's count.
  - invalid or repeat: no map or count change.
- RESP: done=1 for one cycle, then return to IDLE.
- Result flags: hit/repeat_shot/invalid/win are registered in UPDATE, held until the next accepted shot, and cleared at reset.
- win = (target count == 0) after the update. It is also set on invalid/repeat if the target count is already 0.
- Simultaneous events:
  - shot_req and place_en in the same IDLE cycle → shot wins, placement is dropped.
  - shot_req or place_en while busy → ignored, not queued.
- new_game or rst in any state → IDLE. Maps, counts, flags, done and busy all go to 0 on the next edge; an in-flight shot is abandoned with no done.
- Counts never underflow: a hit can only occur on an occupied unshot cell, so the count is ≥ 1 at that point.

## Timing
- Reset values: busy=0, done=0, hit=0, repeat_shot=0, invalid=0, win=0, ships_p=0, ships_pc=0.
- Shot sampled at edge E0: LOOKUP after E0, UPDATE after E1, RESP after E2 (done=1), IDLE after E3.
- Flags and counts are updated at E2, so they are valid while done is high.
- Minimum shot-to-shot spacing is 4 cycles. A new shot_req is accepted in the first IDLE cycle.
- Placement: single cycle. ships_* reflects it on the next cycle.

## Configuration
- BOARD_CHECK_REPEAT_EN defined: repeat-shot detection as above (repeat_shot=1, hit=0, maps unchanged), so the FSM can let the shooter retry.
- Undefined: repeat_shot is tied to 0 and a repeat shot is classified as a plain miss (hit=0, no count change). Shot-map state is still kept for hit detection.

## Test plan
- Reset, then place player ship (1,2) and PC ships (0,0),(4,4) → ships_p=1, ships_pc=2. Placing PC (0,0) again → ships_pc stays 2.
- Player shot at PC (0,0) → done pulses 3 cycles after accept, hit=1, ships_pc=1, win=0. Shot at PC (4,4) → hit=1, ships_pc=0, win=1.
- PC shot at player (3,3) → hit=0, repeat_shot=0, ships_p=1. Repeat the same shot → repeat_shot=1 with BOARD_CHECK_REPEAT_EN; without it, repeat_shot=0 and hit=0.
- Shot at row 5 (ROWS=5) → invalid=1, hit=0, counts unchanged.
- shot_req and place_en asserted together, then shot_req pulsed again while busy → only the first shot completes, exactly one done, placement absent from counts.
- rst asserted during UPDATE → no done pulse, all outputs 0 next cycle, ships_p=ships_pc=0.
